// File: rtl/trig_sequencer_808_if.sv
// Pattern-write bus for the 808 trig sequencer: one 2-bit step entry per strobe.
interface trig_sequencer_808_if #(
    parameter int unsigned NUM_STEPS = 16
);
    localparam int unsigned IDX_BITS = $clog2(NUM_STEPS);

    logic                pattern_we;
    logic [IDX_BITS-1:0] pattern_addr;
    logic [1:0]          pattern_wdata;

    modport master (output pattern_we, output pattern_addr, output pattern_wdata);
    modport slave  (input  pattern_we, input  pattern_addr, input  pattern_wdata);
endinterface

// File: rtl/trig_sequencer_808.sv
// Tempo-locked step sequencer driving the trig/accent inputs of the 808 one-shot voice.
// Steps are counted in sample ticks recovered from pblrc; each hit fires a clamped-length gate.
module trig_sequencer_808 #(
    parameter int unsigned NUM_STEPS  = 16,
    parameter int unsigned TEMPO_BITS = 16,
    parameter int unsigned GATE_BITS  = 8
) (
    input  logic                         mclk,
    input  logic                         rst,
    input  logic                         pblrc,
    input  logic                         run,
    input  logic [TEMPO_BITS-1:0]        step_period,
    input  logic [GATE_BITS-1:0]         gate_len,
    input  logic [$clog2(NUM_STEPS)-1:0] last_step,
    trig_sequencer_808_if.slave          pat,
    output logic                         trig,
    output logic                         accent,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         step_tick
);
    localparam int unsigned IDX_BITS = $clog2(NUM_STEPS);
    localparam int unsigned CMP_BITS = (TEMPO_BITS > GATE_BITS) ? TEMPO_BITS : GATE_BITS;

    typedef enum logic [0:0] {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  pb_s1, pb_s2, pb_s3, tick;
    logic [TEMPO_BITS-1:0] sample_cnt;
    logic [TEMPO_BITS-1:0] period_q;
    logic [GATE_BITS-1:0]  gate_cnt;
    logic [1:0]            pattern [NUM_STEPS];

    logic [TEMPO_BITS-1:0] period_c;
    logic [CMP_BITS-1:0]   gate_ext_c;
    logic [CMP_BITS-1:0]   limit_ext_c;
    logic [GATE_BITS-1:0]  gate_c;
    logic [IDX_BITS-1:0]   next_idx_c;
    logic [1:0]            entry_c;
    logic                  active_c;

    always_ff @(posedge mclk) begin
        if (rst) state <= STOPPED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            STOPPED: if (run)  state_nxt = RUNNING;
            RUNNING: if (!run) state_nxt = STOPPED;
            default:           state_nxt = STOPPED;
        endcase
    end

    // pblrc synchronizer and rising-edge sample tick
    always_ff @(posedge mclk) begin
        if (rst) begin
            pb_s1 <= 1'b0;
            pb_s2 <= 1'b0;
            pb_s3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            pb_s1 <= pblrc;
            pb_s2 <= pb_s1;
            pb_s3 <= pb_s2;
            tick  <= pb_s2 & ~pb_s3;
        end
    end

    // Gate is clamped to P-1 so trig always drops for a tick before the next boundary
    always_comb begin
        period_c    = (step_period < TEMPO_BITS'(2)) ? TEMPO_BITS'(2) : step_period;
        gate_ext_c  = CMP_BITS'(gate_len);
        limit_ext_c = CMP_BITS'(period_c - TEMPO_BITS'(1));
        gate_c      = GATE_BITS'((gate_ext_c < limit_ext_c) ? gate_ext_c : limit_ext_c);
        next_idx_c  = (step_idx >= last_step) ? '0 : step_idx + IDX_BITS'(1);
        active_c    = (state == RUNNING) && run;
        entry_c     = pattern[step_idx];
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            sample_cnt <= '0;
            period_q   <= TEMPO_BITS'(2);
            gate_cnt   <= '0;
            trig       <= 1'b0;
            accent     <= 1'b0;
            step_idx   <= '0;
            step_tick  <= 1'b0;
            for (int i = 0; i < int'(NUM_STEPS); i++) pattern[i] <= 2'b00;
        end else begin
            step_tick <= 1'b0;
            if (pat.pattern_we) pattern[pat.pattern_addr] <= pat.pattern_wdata;

            if (!active_c) begin
                sample_cnt <= '0;
                gate_cnt   <= '0;
                trig       <= 1'b0;
                step_idx   <= '0;
            end else if (tick) begin
                if (sample_cnt == '0) begin
                    // step boundary: latch timing and fire the stored hit
                    step_tick  <= 1'b1;
                    period_q   <= period_c;
                    sample_cnt <= TEMPO_BITS'(1);
                    if (entry_c[0]) begin
                        trig     <= (gate_c != '0);
                        accent   <= entry_c[1];
                        gate_cnt <= gate_c;
                    end
                end else begin
                    if (sample_cnt == period_q - TEMPO_BITS'(1)) begin
                        sample_cnt <= '0;
                        step_idx   <= next_idx_c;
                    end else begin
                        sample_cnt <= sample_cnt + TEMPO_BITS'(1);
                    end
                    if (gate_cnt != '0) begin
                        gate_cnt <= gate_cnt - GATE_BITS'(1);
                        if (gate_cnt == GATE_BITS'(1)) trig <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
